// File: rtl/march_element_sequencer.sv
// march_element_sequencer
//
// Runs one march element at a time on behalf of the BIST controller. It
// steers the PMBIST address counter (mode, start/reverse initialisation,
// hold, direction), counts the addresses the element has visited, and hands
// a per-address stream of op slots to the operation engine over a
// valid/ready handshake. Element completion is reported as a pulse.
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   start, abort       begin an element (IDLE only) / terminate immediately
//   elem_admd          address mode for the element (LIUD, PRUD, AC)
//   elem_updwn         address order (ADDR_UP = ascending)
//   elem_nops_m1       number of ops per address minus one
//   tas_in             address currently presented by the counter
//   op_ready           op engine accepts the current op slot
//   admd_out .. updwn_out   controls to the address counter
//   op_valid, op_idx, op_addr, op_last_addr   op slot to the op engine
//   busy               element in progress
//   elem_done          one-cycle pulse after the final op handshake
//   cfg_err            one-cycle pulse after a start with an unsupported mode

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef IR_BFW_ADMD
`define IR_BFW_ADMD 2
`endif
`ifndef ADMD_LIUD
`define ADMD_LIUD 2'd0
`endif
`ifndef ADMD_PRUD
`define ADMD_PRUD 2'd1
`endif
`ifndef ADMD_AC
`define ADMD_AC 2'd2
`endif
`ifndef ADDR_UP
`define ADDR_UP 1'b1
`endif

module march_element_sequencer #(
    parameter int tasw = `ADDR_WIDTH,
    parameter int admw = `IR_BFW_ADMD,
    parameter int opw  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [admw-1:0] elem_admd,
    input  logic            elem_updwn,
    input  logic [opw-1:0]  elem_nops_m1,
    input  logic [tasw-1:0] tas_in,
    input  logic            op_ready,
    output logic [admw-1:0] admd_out,
    output logic            s_out,
    output logic            r_out,
    output logic            hold_out,
    output logic            updwn_out,
    output logic            op_valid,
    output logic [opw-1:0]  op_idx,
    output logic [tasw-1:0] op_addr,
    output logic            op_last_addr,
    output logic            busy,
    output logic            elem_done,
    output logic            cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_OPS  = 2'd2
    } state_t;

    // Final count value: all codes for LIUD/AC, one fewer for PRUD because
    // the LFSR never visits the all-zero code.
    localparam logic [tasw-1:0] LAST_FULL = {tasw{1'b1}};
    localparam logic [tasw-1:0] LAST_PRUD = {{(tasw-1){1'b1}}, 1'b0};

    state_t          state_q, state_d;
    logic [tasw-1:0] addr_cnt_q, addr_cnt_d;
    logic [opw-1:0]  op_idx_q, op_idx_d;
    logic [admw-1:0] admd_q, admd_d;
    logic            updwn_q, updwn_d;
    logic [opw-1:0]  nops_q, nops_d;
    logic            elem_done_q, elem_done_d;
    logic            cfg_err_q, cfg_err_d;

    logic admd_ok;
    logic handshake;
    logic last_op;
    logic last_addr;

    assign admd_ok   = (elem_admd == `ADMD_LIUD) || (elem_admd == `ADMD_PRUD) ||
                       (elem_admd == `ADMD_AC);
    assign handshake = (state_q == ST_OPS) && op_ready;
    assign last_op   = (op_idx_q == nops_q);
    assign last_addr = (admd_q == `ADMD_PRUD) ? (addr_cnt_q == LAST_PRUD)
                                              : (addr_cnt_q == LAST_FULL);

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        op_idx_d    = op_idx_q;
        admd_d      = admd_q;
        updwn_d     = updwn_q;
        nops_d      = nops_q;
        elem_done_d = 1'b0;
        cfg_err_d   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (admd_ok) begin
                            state_d = ST_INIT;
                            admd_d  = elem_admd;
                            updwn_d = elem_updwn;
                            nops_d  = elem_nops_m1;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    state_d    = ST_OPS;
                    addr_cnt_d = '0;
                    op_idx_d   = '0;
                end
                ST_OPS: begin
                    if (handshake) begin
                        if (!last_op) begin
                            op_idx_d = op_idx_q + 1'b1;
                        end else if (!last_addr) begin
                            op_idx_d   = '0;
                            addr_cnt_d = addr_cnt_q + 1'b1;
                        end else begin
                            state_d     = ST_IDLE;
                            elem_done_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_cnt_q  <= '0;
            op_idx_q    <= '0;
            admd_q      <= '0;
            updwn_q     <= 1'b0;
            nops_q      <= '0;
            elem_done_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            op_idx_q    <= op_idx_d;
            admd_q      <= admd_d;
            updwn_q     <= updwn_d;
            nops_q      <= nops_d;
            elem_done_q <= elem_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Counter initialisation: s loads the first ascending address, r the
    // first descending one. In AC mode the counter ignores both.
    assign s_out = (state_q == ST_INIT) && (updwn_q == `ADDR_UP);
    assign r_out = (state_q == ST_INIT) && (updwn_q != `ADDR_UP);

    // Release the counter only on the final op of a non-final address, so it
    // advances on the same edge that retires that op.
    assign hold_out = !(handshake && last_op && !last_addr && !abort);

    assign admd_out     = admd_q;
    assign updwn_out    = updwn_q;
    assign op_valid     = (state_q == ST_OPS);
    assign op_idx       = op_idx_q;
    assign op_addr      = tas_in;
    assign op_last_addr = last_addr;
    assign busy         = (state_q != ST_IDLE);
    assign elem_done    = elem_done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: doc/march_element_sequencer.md
# march_element_sequencer

Control-side partner of the PMBIST address counter. It runs one march element at a time and drives the counter's mode, start, reverse, hold and up/down controls. It also tracks how many addresses the element has visited, hands a per-address stream of operation slots to the operation engine through a valid/ready handshake, and flags element completion to the BIST controller.

## Interface
Parameters:
- tasw, default `ADDR_WIDTH (8): address width; must equal the counter's.
- admw, default `IR_BFW_ADMD: address-mode field width.
- opw, default 3: width of the op-index field (up to 8 ops per address).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  begin an element; sampled only in IDLE.
- abort  in  1  terminate the current element immediately.
- elem_admd  in  admw  address mode: `ADMD_LIUD, `ADMD_PRUD or `ADMD_AC.
- elem_updwn  in  1  order; `ADDR_UP = ascending.
- elem_nops_m1  in  opw  ops per address minus 1.
- tas_in  in  tasw  counter address output; forwarded to the op engine.
- op_ready  in  1  op engine accepts the current op slot.
- admd_out  out  admw  to counter admd_in.
- s_out  out  1  to counter s_in.
- r_out  out  1  to counter r_in.
- hold_out  out  1  to counter hold_in.
- updwn_out  out  1  to counter updwn_in.
- op_valid  out  1  op slot valid.
- op_idx  out  opw  op index within the current address.
- op_addr  out  tasw  equals tas_in.
- op_last_addr  out  1  current address is the element's last.
- busy  out  1  element in progress.
- elem_done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse when start is given with an unsupported admd.

## Operation
- Latched at an accepted start: admd, updwn, nops_m1. The latched values drive admd_out and updwn_out until the next accepted start.
- States:
  - IDLE, INIT and OPS.
  - IDLE → INIT on start when admd is supported and abort=0.
  - IDLE stays IDLE on start with an unsupported admd; cfg_err pulses next cycle.
  - INIT → OPS unconditionally.
  - OPS → IDLE after the last op of the last address is handshaken.
  - Any state → IDLE on abort=1.
- INIT, one cycle:
  - s_out=1 if updwn=`ADDR_UP; otherwise r_out=1.
  - Clears addr_cnt (tasw bits) and op_idx.
- OPS:
  - op_valid=1.
  - Handshake means op_valid & op_ready.
  - On a handshake with op_idx<nops_m1: op_idx increments.
  - On a handshake with op_idx==nops_m1 and the address is not the last: op_idx←0 and addr_cnt increments.
- hold_out=0 only when op_valid & op_ready & op_idx==nops_m1 & !op_last_addr & !abort. It is 1 in every other state and cycle, so the counter steps on the same edge as the last op of an address.
- op_last_addr = (addr_cnt == N-1):
  - N = 2^tasw for LIUD and AC.
  - N = 2^tasw−1 for PRUD (the LFSR never visits 0).
- AC mode: the counter ignores s/r. Because AC sweeps all 2^tasw codes from any count value, no initialisation is needed; the s/r pulse is harmless.
- s_out, r_out, hold_out, op_valid and busy are combinational decodes of registered state (plus op_ready and abort for hold_out).
- elem_done and cfg_err are registered.

## Timing
- Reset (rst=0 at an edge):
  - State IDLE; addr_cnt=0, op_idx=0; latched descriptor cleared to 0.
  - Outputs: s_out=0, r_out=0, hold_out=1, op_valid=0, busy=0, elem_done=0, cfg_err=0.
  - admd_out=0, updwn_out=0.
  - Applies mid-element as well: no elem_done is issued.
- With start sampled at edge t:
  - Cycle t+1 is INIT.
  - Cycle t+2 is OPS: op_valid=1, op_idx=0, tas_in holds the first address.
- With op_ready held at 1, an element occupies N·(nops_m1+1) OPS cycles. elem_done=1 in the cycle after the final handshake; busy=0 in that cycle.
- Stall (op_ready=0): op_idx, addr_cnt and tas_in are frozen and hold_out=1. op_valid stays 1.
- abort sampled at edge a: IDLE at a+1 with busy=0. No elem_done is issued, and hold_out=1 during cycle a.
- start together with abort in IDLE: abort wins and the element does not start.
- start while busy is ignored. Descriptor input changes while busy are ignored.
- addr_cnt never wraps; the element terminates at N-1.

## Test plan
- LIUD, up, nops_m1=0, tasw=8:
  - start at t → s_out=1 only at t+1.
  - op_addr 0..255 on cycles t+2..t+257.
  - op_last_addr only at 255.
  - elem_done=1 at t+258.
- LIUD, down, nops_m1=2:
  - r_out pulse at t+1.
  - Each of addresses 255..0 is presented for 3 cycles with op_idx 0,1,2.
  - hold_out=0 exactly 255 times.
  - elem_done after 768 OPS cycles.
- Stall: in LIUD up, drop op_ready for 5 cycles at op_idx=1 of address 10 → op_idx=1, op_addr=10 and hold_out=1 throughout; the stream resumes unchanged afterward.
- PRUD, up, nops_m1=0:
  - 255 addresses presented, all distinct and nonzero.
  - First address is `ADMD_PR_SEED.
  - elem_done after 255 OPS cycles.
- Abort and restart:
  - Abort at address 40 → busy=0 next cycle and no elem_done.
  - Immediate restart in LIUD up → first op_addr=0.
- Reset and bad mode:
  - rst=0 mid-OPS → all outputs at their reset values next cycle.
  - start with admd not LIUD/PRUD/AC → cfg_err pulse one cycle later, busy stays 0.
